// File: rtl/demux4_seq_if.sv
// Handshake and demux-drive bundle between the upstream source and demux4_seq.
interface demux4_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] lane_mask;
    logic       Y;
    logic       S0;
    logic       S1;
    logic       busy;
    logic       frame_done;

    modport slave (
        input  in_valid, in_data, lane_mask,
        output in_ready, Y, S0, S1, busy, frame_done
    );

    modport master (
        output in_valid, in_data, lane_mask,
        input  in_ready, Y, S0, S1, busy, frame_done
    );
endinterface

// File: rtl/demux4_seq.sv
// Serialises a 4-bit word onto Y with matching S1:S0 select so a demux4 steers
// bit k to output k; masked lanes are skipped and an optional guard cycle is inserted.
module demux4_seq #(
    parameter int unsigned DWELL = 1,
    parameter int unsigned GUARD = 0
) (
    input logic         clk,
    input logic         rst_n,
    demux4_seq_if.slave io
);
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_DRIVE} state_t;

    state_t            state_q, state_d;
    logic [LANES-1:0]  data_q, data_d, mask_q, mask_d;
    logic [LANE_W-1:0] lane_q, lane_d, sel_q, sel_d;
    logic [LANE_W-1:0] first_lane, next_lane;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              y_q, y_d, busy_q, busy_d, done_q, done_d;
    logic              has_next;
    logic [1:0]        rst_sync_q;
    logic              rst_int_n;

    // Reset asserts asynchronously, releases two clocks later in sync with clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Lowest enabled lane of the incoming mask, next enabled lane above the current one
    always_comb begin
        first_lane = '0;
        next_lane  = lane_q;
        has_next   = 1'b0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (io.lane_mask[i]) first_lane = LANE_W'(i);
            if (mask_q[i] && (i > int'(lane_q))) begin
                next_lane = LANE_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        y_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (io.in_valid) begin
                    data_d = io.in_data;
                    mask_d = io.lane_mask;
                    if (io.lane_mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        lane_d  = first_lane;
                        cnt_d   = RELOAD;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (has_next) begin
                    lane_d  = next_lane;
                    cnt_d   = RELOAD;
                    state_d = (GUARD != 0) ? ST_GUARD : ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_GUARD: state_d = ST_DRIVE;
            default:  state_d = ST_IDLE;
        endcase

        // Registered outputs follow the state being entered
        case (state_d)
            ST_DRIVE: begin
                sel_d  = lane_d;
                y_d    = data_d[lane_d];
                busy_d = 1'b1;
            end
            ST_GUARD: begin
                sel_d  = lane_d;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign io.in_ready   = (state_q == ST_IDLE);
    assign io.Y          = y_q;
    assign io.S1         = sel_q[1];
    assign io.S0         = sel_q[0];
    assign io.busy       = busy_q;
    assign io.frame_done = done_q;
endmodule

// File: tb/tb_demux4_seq.sv
// Directed bench for demux4_seq: three parameterisations, outputs packed as
// {in_ready, busy, frame_done, S1, S0, Y} and compared against hand-computed cycles.
module tb_demux4_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux4_seq_if ifa ();
    demux4_seq_if ifb ();
    demux4_seq_if ifc ();

    demux4_seq #(.DWELL(1), .GUARD(0)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
    demux4_seq #(.DWELL(3), .GUARD(1)) dut_b (.clk(clk), .rst_n(rst_n), .io(ifb));
    demux4_seq #(.DWELL(2), .GUARD(0)) dut_c (.clk(clk), .rst_n(rst_n), .io(ifc));

    logic [5:0] oa, ob, oc;
    assign oa = {ifa.in_ready, ifa.busy, ifa.frame_done, ifa.S1, ifa.S0, ifa.Y};
    assign ob = {ifb.in_ready, ifb.busy, ifb.frame_done, ifb.S1, ifb.S0, ifb.Y};
    assign oc = {ifc.in_ready, ifc.busy, ifc.frame_done, ifc.S1, ifc.S0, ifc.Y};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input logic [3:0] d, input logic [3:0] m);
        case (which)
            0: begin ifa.in_valid = v; ifa.in_data = d; ifa.lane_mask = m; end
            1: begin ifb.in_valid = v; ifb.in_data = d; ifb.lane_mask = m; end
            default: begin ifc.in_valid = v; ifc.in_data = d; ifc.lane_mask = m; end
        endcase
    endtask

    // Ticks n cycles checking one packed output vector per cycle
    task automatic expect_seq(input string tag, input int which, input bit drop_valid,
                              input bit scramble, input int n, input logic [5:0] exp [12]);
        logic [5:0] got;
        for (int i = 0; i < n; i++) begin
            tick();
            if (scramble)
                drive(which, 1'b0, 4'($urandom), 4'($urandom));
            else if (drop_valid && i == 0)
                drive(which, 1'b0, 4'b0000, 4'b0000);
            got = (which == 0) ? oa : (which == 1) ? ob : oc;
            check($sformatf("%s c%0d", tag, i + 1), 8'(got), 8'(exp[i]));
        end
    endtask

    initial begin
        drive(0, 1'b0, 4'b0000, 4'b0000);
        drive(1, 1'b0, 4'b0000, 4'b0000);
        drive(2, 1'b0, 4'b0000, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("reset a", 8'(oa), 8'b100000);
        check("reset b", 8'(ob), 8'b100000);
        check("reset c", 8'(oc), 8'b100000);

        // Full mask, DWELL=1: lanes 0..3 then a done cycle holding select 11
        drive(0, 1'b1, 4'b1010, 4'b1111);
        expect_seq("t1", 0, 1'b1, 1'b0, 6, '{6'b010000, 6'b010011, 6'b010100, 6'b010111,
                   6'b101110, 6'b100110, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});

        // Empty mask: done next cycle, no lane activity, select unchanged
        drive(0, 1'b1, 4'b1111, 4'b0000);
        expect_seq("t3", 0, 1'b1, 1'b0, 2, '{6'b101110, 6'b100110,
                   6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});

        // Back-to-back: second word accepted on the frame_done cycle
        drive(0, 1'b1, 4'b0001, 4'b1111);
        expect_seq("t4a", 0, 1'b0, 1'b0, 1, '{6'b010001,
                   6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});
        drive(0, 1'b1, 4'b1000, 4'b1111);
        expect_seq("t4b", 0, 1'b0, 1'b0, 5, '{6'b010010, 6'b010100, 6'b010110, 6'b101110,
                   6'b010000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});
        drive(0, 1'b0, 4'b0000, 4'b0000);
        expect_seq("t4c", 0, 1'b0, 1'b0, 5, '{6'b010010, 6'b010100, 6'b010111, 6'b101110,
                   6'b100110, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});

        // DWELL=3 with guard: lane 0 x3, guard on lane 2, lane 2 x3, done
        drive(1, 1'b1, 4'b0111, 4'b0101);
        expect_seq("t2", 1, 1'b1, 1'b0, 9, '{6'b010001, 6'b010001, 6'b010001, 6'b010100,
                   6'b010101, 6'b010101, 6'b010101, 6'b101100, 6'b100100, 6'b0, 6'b0, 6'b0});

        // Inputs scrambled every cycle while busy; only the captured word matters
        drive(1, 1'b1, 4'b0010, 4'b1011);
        expect_seq("t6", 1, 1'b1, 1'b1, 12, '{6'b010000, 6'b010000, 6'b010000, 6'b010010,
                   6'b010011, 6'b010011, 6'b010011, 6'b010110,
                   6'b010110, 6'b010110, 6'b010110, 6'b101110});
        drive(1, 1'b0, 4'b0000, 4'b0000);

        // Reset asserted mid lane 2 of a DWELL=2 frame
        drive(2, 1'b1, 4'b0100, 4'b1111);
        expect_seq("t5a", 2, 1'b1, 1'b0, 5, '{6'b010000, 6'b010000, 6'b010010, 6'b010010,
                   6'b010101, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 async clear", 8'(oc), 8'b100000);
        tick();
        check("t5 held", 8'(oc), 8'b100000);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("t5 release", 8'(oc), 8'b100000);
        check("t5 other dut", 8'(oa), 8'b100000);
        drive(2, 1'b1, 4'b1001, 4'b1001);
        expect_seq("t5b", 2, 1'b1, 1'b0, 6, '{6'b010001, 6'b010001, 6'b010111, 6'b010111,
                   6'b101110, 6'b100110, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
